// File: rtl/alu_mul_seq.sv
// Shift-add N x N -> 2N unsigned multiply sequencer that borrows the shared ALU
// for its adds. It does one step per cycle, and the ALU carry-out feeds the top bit of the high half.
module alu_mul_seq #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    output logic [1:0]     alu_ctrl,
    input  logic [N-1:0]   alu_result,
    input  logic [3:0]     alu_flags,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic           prod_zero
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [N-1:0]      m;
    logic [N-1:0]      p_hi;
    logic [N-1:0]      p_lo;
    logic [CW-1:0]     count;
    logic [2*N-1:0]    next_p;
    logic              unused_flags;

    // {carry, sum, p_lo} shifted right by one, keeping the low 2N bits.
    assign next_p       = {alu_flags[1], alu_result, p_lo[N-1:1]};
    assign unused_flags = ^{alu_flags[3:2], alu_flags[0]};

    assign alu_ctrl = 2'b00;
    assign busy     = (state != IDLE);

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        if (state == ITER) begin
            alu_a = p_hi;
            alu_b = p_lo[0] ? m : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            done      <= 1'b0;
            product   <= '0;
            prod_zero <= 1'b1;
            count     <= '0;
            m         <= '0;
            p_hi      <= '0;
            p_lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= a;
                        p_hi  <= '0;
                        p_lo  <= b;
                        count <= '0;
                        state <= ITER;
                    end
                end
                ITER: begin
                    {p_hi, p_lo} <= next_p;
                    count        <= count + 1'b1;
                    // The product is captured on the last step, so it is valid alongside done.
                    if (count == CW'(N - 1)) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        product   <= next_p;
                        prod_zero <= ~|next_p;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq. It contains a behavioural ALU and checks each product against a queue of
// expected products that is filled when a multiply is accepted.
module tb_alu_mul_seq;
    localparam int N = 32;

    logic           clk;
    logic           reset;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [N-1:0]   alu_a;
    logic [N-1:0]   alu_b;
    logic [1:0]     alu_ctrl;
    logic [N-1:0]   alu_result;
    logic [3:0]     alu_flags;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;
    logic           prod_zero;

    logic [N:0]     alu_sum;
    logic [2*N-1:0] exp_q[$];
    int             checks;
    int             errors;

    alu_mul_seq #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .busy(busy), .done(done), .product(product), .prod_zero(prod_zero)
    );

    // ALU: ctrl 00 adds and anything else subtracts. Flags are {N,Z,C,V}.
    assign alu_sum    = (alu_ctrl == 2'b00) ? ({1'b0, alu_a} + {1'b0, alu_b})
                                            : ({1'b0, alu_a} + {1'b0, ~alu_b} + 1'b1);
    assign alu_result = alu_sum[N-1:0];
    assign alu_flags  = {alu_sum[N-1], ~|alu_sum[N-1:0], alu_sum[N], 1'b0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (product !== '0) begin errors++; $display("FAIL reset_product: got %h want 0", product); end
        checks++; if (prod_zero !== 1'b1) begin errors++; $display("FAIL reset_prod_zero: got %b want 1", prod_zero); end
        checks++; if (alu_a !== '0 || alu_b !== '0) begin errors++; $display("FAIL reset_alu_ops: got %h/%h want 0/0", alu_a, alu_b); end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Starts one multiply and waits for done. The caller must be at 1 time unit after a clock edge.
    // When hold is set, start stays high with changing a/b while the multiply runs.
    task automatic run_mul(input logic [N-1:0] op_a, input logic [N-1:0] op_b, input bit hold);
        int             lat;
        int             wait_cnt;
        bit             busy_ok;
        logic [2*N-1:0] exp;
        start = 1'b1;
        a = op_a;
        b = op_b;
        wait_cnt = 0;
        while (busy === 1'b1 && wait_cnt < 100) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        @(posedge clk);
        exp_q.push_back((2*N)'(op_a) * (2*N)'(op_b));
        #1;
        lat = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1 || alu_ctrl !== 2'b00) busy_ok = 1'b0;
            start = hold;
            a = $urandom;
            b = $urandom;
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL mul_timeout: no done for %h*%h after %0d cycles", op_a, op_b, lat);
            exp_q.delete();
        end else begin
            exp = exp_q.pop_front();
            if (product !== exp) begin
                errors++;
                $display("FAIL mul_product: %h*%h got %h want %h", op_a, op_b, product, exp);
            end
            checks++;
            if (prod_zero !== (exp == '0)) begin
                errors++;
                $display("FAIL mul_prod_zero: got %b want %b", prod_zero, (exp == '0));
            end
        end
        checks++;
        if (lat != N + 1) begin errors++; $display("FAIL mul_latency: got %0d want %0d", lat, N + 1); end
        checks++;
        if (!busy_ok) begin errors++; $display("FAIL mul_busy_ctrl: busy or alu_ctrl wrong during ITER"); end
        if (!hold) start = 1'b0;
    endtask

    task automatic test_basic();
        logic [2*N-1:0] held;
        run_mul(32'd3, 32'd5, 1'b0);
        held = product;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || product !== held) begin
            errors++;
            $display("FAIL basic_after_done: done=%b busy=%b product=%h want 0/0/%h", done, busy, product, held);
        end
    endtask

    task automatic test_boundaries();
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_mul(32'h1234, 32'h0, 1'b0);
        run_mul(32'h0, 32'hDEAD_BEEF, 1'b0);
        run_mul(32'h8000_0000, 32'h2, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_mul(32'd11, 32'd13, 1'b1);
        run_mul(32'hABCD_0123, 32'h0F0F_F0F0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            run_mul($urandom, $urandom_range(1, 32'hFFFF), 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        start = 1'b1;
        a = 32'd7;
        b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
        checks++; if (product !== '0) begin errors++; $display("FAIL midreset_product: got %h want 0", product); end
        checks++; if (prod_zero !== 1'b1) begin errors++; $display("FAIL midreset_prod_zero: got %b want 1", prod_zero); end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL midreset_idle: got done/busy activity want none"); end
        run_mul(32'd7, 32'd9, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_boundaries();
        test_back_to_back();
        test_random();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL queue_empty: got %0d left want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
